// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Byte-wide 8N1 UART transmitter with a store-side FIFO. Bytes
//             written from the core's peripheral port are queued and sent
//             LSB first on txd at a fixed clock divisor. Pushes into a full
//             FIFO are dropped and latched in a sticky overflow flag.
//  Ports    : clk      - rising-edge clock
//             reset    - asynchronous active-low reset
//             din      - store data, only [7:0] is transmitted
//             we       - one-cycle push strobe
//             txd      - registered serial line, idle high
//             busy     - FIFO non-empty or a frame in progress
//             full     - FIFO holds 2^FIFO_LOG2 bytes
//             empty    - FIFO holds no bytes
//             level    - FIFO occupancy
//             overflow - sticky, a push was dropped since reset
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int FIFO_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          din,
    input  logic                 we,
    output logic                 txd,
    output logic                 busy,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   level,
    output logic                 overflow
);

    localparam int                 c_DEPTH     = 1 << FIFO_LOG2;
    localparam int                 c_CW        = $clog2(CLK_DIV);
    localparam logic [c_CW-1:0]    c_BAUD_LAST = c_CW'(CLK_DIV - 1);
    localparam logic [FIFO_LOG2:0] c_FULL      = (FIFO_LOG2 + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [c_CW-1:0]        baud_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic                   txd_q;

    logic [7:0]             mem_q [c_DEPTH];
    logic [FIFO_LOG2-1:0]   wptr_q;
    logic [FIFO_LOG2-1:0]   rptr_q;
    logic [FIFO_LOG2:0]     count_q;
    logic [FIFO_LOG2:0]     count_d;
    logic                   overflow_q;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_bit_end;

    // Upper store bits carry no meaning for a byte-wide peripheral.
    logic                   w_unused_din;
    assign w_unused_din = ^din[31:8];

    assign full      = (count_q == c_FULL);
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign overflow  = overflow_q;
    assign busy      = !empty || (state_q != S_IDLE);
    assign txd       = txd_q;

    // Full is the pre-edge value: a pop in the same cycle does not make room.
    assign w_push    = we && !full;
    assign w_bit_end = (baud_q == c_BAUD_LAST);
    // Pops happen from IDLE, or on the final STOP cycle for gapless frames.
    assign w_pop     = !empty && ((state_q == S_IDLE) ||
                                  ((state_q == S_STOP) && w_bit_end));

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (we && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wptr_q] <= din[7:0];
        end
    end

    // txd is loaded with the value of the state/bit being entered so the
    // line changes on the same edge as the transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    txd_q  <= 1'b1;
                    if (w_pop) begin
                        shift_q <= mem_q[rptr_q];
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        baud_q  <= '0;
                        idx_q   <= '0;
                        state_q <= S_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        baud_q <= '0;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 3'd1;
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        baud_q <= '0;
                        if (w_pop) begin
                            shift_q <= mem_q[rptr_q];
                            state_q <= S_START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx. A queue-based reference model
//             predicts FIFO occupancy, drops and the cycle each frame starts;
//             a serial-line monitor decodes txd and compares every frame
//             against the expected-frame queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CD    = 4;
    localparam int LOG2  = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * CD;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     din   = '0;
    logic            we    = 1'b0;
    logic            txd;
    logic            busy;
    logic            full;
    logic            empty;
    logic            overflow;
    logic [LOG2:0]   level;

    uart_tx #(.CLK_DIV(CD), .FIFO_LOG2(LOG2)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .we       (we),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] b;
        int         c;
    } frame_t;

    // Reference model state: bytes waiting, frames expected on the line,
    // the edge at which the transmitter can next accept a byte.
    frame_t      exp_q[$];
    logic [7:0]  mfifo[$];
    int          cyc       = 0;
    int          next_free = 0;
    bit          m_ovf     = 1'b0;
    bit          m_full_pre;
    frame_t      m_f;

    // Line monitor state.
    bit          mon_active = 1'b0;
    int          mon_n      = 0;
    int          mon_start  = 0;
    bit          mon_glitch = 1'b0;
    logic [9:0]  mon_bits   = '0;
    frame_t      mon_f;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // A byte enters the transmitter whenever one is waiting and the previous
    // frame (10*CLK_DIV cycles long) has reached its final edge.
    initial begin : model
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mfifo.delete();
                exp_q.delete();
                m_ovf     = 1'b0;
                next_free = 0;
            end else begin
                cyc++;
                m_full_pre = (mfifo.size() == DEPTH);
                if (mfifo.size() != 0 && cyc >= next_free) begin
                    m_f.b = mfifo.pop_front();
                    m_f.c = cyc;
                    exp_q.push_back(m_f);
                    next_free = cyc + FRAME;
                end
                if (we) begin
                    if (m_full_pre) m_ovf = 1'b1;
                    else            mfifo.push_back(din[7:0]);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_active = 1'b0;
            end else begin
                check("status{busy,full,empty,ovf,level}",
                      {busy, full, empty, overflow, level},
                      {(mfifo.size() != 0) || (cyc < next_free),
                       mfifo.size() == DEPTH, mfifo.size() == 0, m_ovf,
                       5'(mfifo.size())});
                if (!mon_active && txd !== 1'b1) begin
                    mon_active = 1'b1;
                    mon_n      = 0;
                    mon_start  = cyc;
                    mon_glitch = 1'b0;
                end
                if (mon_active) begin
                    if (mon_n % CD == 0)                   mon_bits[mon_n / CD] = txd;
                    else if (txd !== mon_bits[mon_n / CD]) mon_glitch = 1'b1;
                    mon_n++;
                    if (mon_n == FRAME) begin
                        mon_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_frame: got bits %b, none expected (cycle %0d)",
                                     mon_bits, cyc);
                        end else begin
                            mon_f = exp_q.pop_front();
                            check("frame{glitch,stop,data,start}", {mon_glitch, mon_bits},
                                  {1'b0, 1'b1, mon_f.b, 1'b0});
                            check("frame_start_cycle", mon_start, mon_f.c);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input bit w, input logic [31:0] d);
        we  = w;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, $urandom);
    endtask

    initial begin : stimulus
        int t;
        #1 reset = 1'b0;
        #1;
        check("rst_txd",      txd,      1);
        check("rst_busy",     busy,     0);
        check("rst_full",     full,     0);
        check("rst_empty",    empty,    1);
        check("rst_level",    level,    0);
        check("rst_overflow", overflow, 0);
        #20 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single byte, then two back-to-back with junk in the upper bits.
        tick(1'b1, 32'h0000_0055);
        idle(50);
        tick(1'b1, 32'hABCD_EF41);
        tick(1'b1, 32'h0000_00C3);
        idle(90);

        // 18 consecutive pushes: the 17th fills the FIFO, the 18th drops.
        for (int i = 0; i < 18; i++) tick(1'b1, i);
        idle(17 * FRAME + 20);
        check("overflow_sticky", overflow, 1);

        // Asynchronous reset in the middle of a frame's data bits.
        tick(1'b1, 32'h0000_0000);
        tick(1'b1, 32'h0000_003C);
        idle(11);
        check("pre_rst_txd",   txd,   0);
        check("pre_rst_level", level, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_txd",      txd,      1);
        check("midrst_level",    level,    0);
        check("midrst_overflow", overflow, 0);
        check("midrst_busy",     busy,     0);
        check("midrst_empty",    empty,    1);
        idle(3);
        #2 reset = 1'b1;
        idle(20);
        tick(1'b1, 32'h0000_00A5);
        idle(50);

        // Pointer wrap: 40 bytes, one per frame time.
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, $urandom);
            idle(FRAME - 1);
        end
        check("wrap_no_overflow", overflow, 0);

        // Random gaps and a long burst to provoke drops.
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, $urandom);
            idle($urandom_range(0, 60));
        end
        for (int i = 0; i < 24; i++) tick(1'b1, $urandom);

        t = 0;
        while ((exp_q.size() != 0 || mfifo.size() != 0 || mon_active ||
                cyc < next_free) && t < 20000) begin
            idle(1);
            t++;
        end
        check("drain_within_budget", t < 20000, 1);
        idle(5);
        check("final_txd_idle", txd, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
